// File: rtl/vseq_store_txn_sched.sv
// Unit-stride vector store scheduler: splits [S,E) into AXI INCR bursts at 4 KiB and
// max-burst boundaries, issues AW, streams per-beat control records and gathers B.
module vseq_store_txn_sched #(
    parameter  int AxiDataWidth   = 128,
    parameter  int AxiAddrWidth   = 64,
    parameter  int VlWidth        = 16,
    parameter  int MaxBurstLen    = 256,
    parameter  int MaxOutstanding = 8,
    localparam int BusBytes       = AxiDataWidth / 8,
    localparam int BusNibbles     = AxiDataWidth / 4,
    localparam int BusNSize       = $clog2(BusNibbles)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [VlWidth-1:0]      req_vl_i,
    input  logic [VlWidth-1:0]      req_vstart_i,
    input  logic [1:0]              req_sew_i,
    output logic                    meta_glb_valid_o,
    input  logic                    meta_glb_ready_i,
    output logic [VlWidth-1:0]      meta_glb_vstart_o,
    output logic [1:0]              meta_glb_sew_o,
    output logic                    axi_aw_valid_o,
    input  logic                    axi_aw_ready_i,
    output logic [AxiAddrWidth-1:0] axi_aw_addr_o,
    output logic [7:0]              axi_aw_len_o,
    output logic [2:0]              axi_aw_size_o,
    output logic [1:0]              axi_aw_burst_o,
    output logic                    txn_ctrl_valid_o,
    input  logic                    txn_ctrl_ready_i,
    output logic [AxiAddrWidth:0]   txn_nb_addr_o,
    output logic                    txn_is_head_o,
    output logic [7:0]              txn_rmn_beat_o,
    output logic [BusNSize:0]       txn_lbn_o,
    output logic                    txn_is_final_txn_o,
    input  logic                    axi_b_valid_i,
    output logic                    axi_b_ready_o,
    input  logic [1:0]              axi_b_resp_i,
    output logic                    done_valid_o,
    input  logic                    done_ready_i,
    output logic                    done_err_o
);

    localparam int BSize = $clog2(BusBytes);
    localparam int AW    = AxiAddrWidth + 1;
    localparam int OW    = $clog2(MaxOutstanding + 1);

    typedef enum logic [2:0] {IDLE, META, ISSUE, WAIT_B, DONE} state_e;

    state_e              r_state;
    logic [AW-1:0]       r_cur;
    logic [AW-1:0]       r_end;
    logic [VlWidth-1:0]  r_vstart;
    logic [1:0]          r_sew;
    logic                r_aw_done;
    logic                r_beats_done;
    logic [7:0]          r_bcnt;
    logic [OW-1:0]       r_out;
    logic                r_err;

    logic [AW-1:0]       w_s, w_e, w_rem, w_pg, w_mb, w_min1, w_len_b, w_span, w_nxt;
    logic [BSize-1:0]    w_eoff;
    logic [7:0]          w_aw_len;
    logic                w_empty, w_final, w_aw_hs, w_tx_hs, w_b_hs, w_aw_ok, w_bt_ok;

    assign w_s     = {1'b0, req_addr_i} + (AW'(req_vstart_i) << req_sew_i);
    assign w_e     = {1'b0, req_addr_i} + (AW'(req_vl_i) << req_sew_i);
    assign w_empty = (req_vl_i <= req_vstart_i);

    // Burst length is the tightest of: bytes left, bytes to the 4 KiB page end, and
    // what fits in MaxBurstLen beats given the unaligned start offset.
    assign w_rem   = r_end - r_cur;
    assign w_pg    = AW'(13'd4096 - {1'b0, r_cur[11:0]});
    assign w_mb    = AW'(MaxBurstLen * BusBytes) - AW'(r_cur[BSize-1:0]);
    assign w_min1  = (w_rem < w_pg) ? w_rem : w_pg;
    assign w_len_b = (w_min1 < w_mb) ? w_min1 : w_mb;
    assign w_span  = AW'(r_cur[BSize-1:0]) + w_len_b;
    assign w_aw_len = 8'((w_span - AW'(1)) >> BSize);
    assign w_nxt   = r_cur + w_len_b;
    assign w_eoff  = w_nxt[BSize-1:0];
    assign w_final = (w_nxt == r_end);

    assign req_ready_o       = (r_state == IDLE);
    assign meta_glb_valid_o  = (r_state == META);
    assign meta_glb_vstart_o = r_vstart;
    assign meta_glb_sew_o    = r_sew;

    assign axi_aw_valid_o = (r_state == ISSUE) && !r_aw_done && (r_out < OW'(MaxOutstanding));
    assign axi_aw_addr_o  = r_cur[AxiAddrWidth-1:0];
    assign axi_aw_len_o   = w_aw_len;
    assign axi_aw_size_o  = 3'(BSize);
    assign axi_aw_burst_o = 2'b01;

    assign txn_ctrl_valid_o   = (r_state == ISSUE) && !r_beats_done;
    assign txn_nb_addr_o      = {r_cur[AxiAddrWidth-1:0], 1'b0};
    assign txn_is_head_o      = (r_bcnt == 8'd0);
    assign txn_rmn_beat_o     = w_aw_len - r_bcnt;
    assign txn_lbn_o          = (w_eoff == '0) ? (BusNSize+1)'(BusNibbles) : {1'b0, w_eoff, 1'b0};
    assign txn_is_final_txn_o = w_final;

    assign axi_b_ready_o = (r_out != '0);
    assign done_valid_o  = (r_state == DONE);
    assign done_err_o    = r_err;

    assign w_aw_hs = axi_aw_valid_o & axi_aw_ready_i;
    assign w_tx_hs = txn_ctrl_valid_o & txn_ctrl_ready_i;
    assign w_b_hs  = axi_b_valid_i & axi_b_ready_o;
    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_bt_ok = r_beats_done | (w_tx_hs & (r_bcnt == w_aw_len));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_end        <= '0;
            r_vstart     <= '0;
            r_sew        <= '0;
            r_aw_done    <= 1'b0;
            r_beats_done <= 1'b0;
            r_bcnt       <= '0;
            r_out        <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid_i) begin
                    r_cur        <= w_s;
                    r_end        <= w_e;
                    r_vstart     <= req_vstart_i;
                    r_sew        <= req_sew_i;
                    r_aw_done    <= 1'b0;
                    r_beats_done <= 1'b0;
                    r_bcnt       <= '0;
                    r_state      <= w_empty ? DONE : META;
                end
                META: if (meta_glb_ready_i) r_state <= ISSUE;
                ISSUE: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_tx_hs) begin
                        if (r_bcnt == w_aw_len) r_beats_done <= 1'b1;
                        else                    r_bcnt <= r_bcnt + 8'd1;
                    end
                    // AW and the last beat may complete in either order; advance once both have.
                    if (w_aw_ok && w_bt_ok) begin
                        r_cur        <= w_nxt;
                        r_aw_done    <= 1'b0;
                        r_beats_done <= 1'b0;
                        r_bcnt       <= '0;
                        if (w_final) r_state <= WAIT_B;
                    end
                end
                WAIT_B: if (r_out == '0) r_state <= DONE;
                DONE: if (done_ready_i) begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
            if (w_aw_hs && !w_b_hs)      r_out <= r_out + OW'(1);
            else if (!w_aw_hs && w_b_hs) r_out <= r_out - OW'(1);
            if (w_b_hs && (axi_b_resp_i != 2'b00)) r_err <= 1'b1;
        end
    end

endmodule
